hanoi_move_gen: RTL
===================

Name: hanoi_move_gen

Overview:
- Move sequencer (initiator side) for the peg-puzzle model.
- Emits the optimal iterative Tower-of-Hanoi move sequence for an S-disk single-colour stack, from a chosen source peg to a chosen destination peg.
- Output is one (fr, to) pair per accepted handshake, in the puzzle's 2-bit peg encoding (00 left, 01 middle, 10 right).
- Drives the puzzle model's fr/to inputs; the bench closes the loop by checking that the model reaches the full-stack-on-destination state.

Parameters:
- S, 5, number of disks in the stack (1..8); the full sequence is 2^S-1 moves.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a new sequence; sampled only in IDLE
- src_peg  in  2  source peg, latched on an accepted start
- dst_peg  in  2  destination peg, latched on an accepted start
- abort  in  1  cancel the running sequence
- mv_valid  out  1  fr/to/mv_disk hold a valid move
- mv_ready  in  1  consumer accepts the move
- fr  out  2  move source peg
- to  out  2  move destination peg
- mv_disk  out  $clog2(S)+1  index of the disk moved (0 = smallest)
- mv_cnt  out  S  number of moves accepted in the current sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after the final move is accepted
- err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: one clock, synchronous and active-high, as stated under Ports. On rst: state IDLE; mv_valid=0, fr=00, to=00, mv_disk=0, mv_cnt=0, busy=0, done=0, err=0; all disk_peg[i]=logical 0. Reset mid-sequence abandons the sequence immediately.
- States: IDLE, RUN, FIN.
- IDLE, start=1, src_peg!=dst_peg, neither peg is 11:
  - Latch src and dst; aux = 3 - src - dst.
  - Clear mv_cnt; set all disk_peg to logical 0.
  - Go to RUN next cycle; busy=1 from that cycle.
- IDLE, start=1 with an illegal peg pair: err=1 for one cycle; stay in IDLE; no moves.
- RUN, mv_valid=1 every cycle:
  - m = mv_cnt+1 (1-based move number).
  - d = count of trailing zeros of m; mv_disk = d.
  - Logical from-peg lf = disk_peg[d].
  - If (S-d) is odd, the disk cycles 0->2->1->0; if even, it cycles 0->1->2->0. lt = the next peg in that cycle.
  - Logical-to-physical map: 0->src, 1->aux, 2->dst. fr = map(lf), to = map(lt).
  - Outputs are a registered or combinational function of state only; no combinational path from mv_ready.
- Handshake:
  - A move is accepted when mv_valid & mv_ready.
  - On accept: disk_peg[d] <= lt; mv_cnt <= mv_cnt+1.
  - While mv_ready=0: fr, to, mv_disk and mv_cnt hold stable.
  - Next move appears the cycle after accept; back-to-back at 1 move/cycle when mv_ready is held high.
- Last move: accept when mv_cnt == 2^S-2 -> FIN next cycle. In FIN: done=1, mv_valid=0, busy=0 for one cycle; then IDLE. mv_cnt holds 2^S-1 until the next start.
- abort=1 in RUN:
  - Next cycle is IDLE, mv_valid=0, busy=0, no done.
  - A handshake in the same cycle as abort is still counted.
  - abort in IDLE/FIN has no effect.
- start while busy or in FIN: ignored; no err.
- Invariant: every emitted move has fr!=to and neither is 11. No move ever places a disk on a smaller one; verify with a shadow peg model.
- mv_cnt never wraps; S-bit width suffices since the maximum value is 2^S-1.

Test Plan:
- S=3, src=00, dst=10, mv_ready=1 -> (fr,to) = 00->10, 00->01, 10->01, 00->10, 01->00, 01->10, 00->10; mv_disk = 0,1,0,2,0,1,0; done pulses once; mv_cnt=7.
- S=3, src=10, dst=00 -> 10->00, 10->01, 00->01, 10->00, 01->10, 01->00, 10->00.
- S=3, src=00, dst=10, mv_ready low 3 cycles after first mv_valid -> fr=00, to=10, mv_cnt=0 held stable for 3 cycles; first accept on cycle 4.
- start with src=01, dst=01, then src=11, dst=00 -> err pulses each time; mv_valid stays 0; busy stays 0.
- S=5, abort after 4 accepted moves -> IDLE next cycle, mv_cnt=4, no done. Restart -> full 31-move sequence; puzzle model ends with the stack on dst.
- S=1, src=01, dst=00 -> single move 01->00, mv_disk=0, done the cycle after accept. rst asserted mid-run (S=5, move 10) -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/hanoi_move_gen.sv
// Tower-of-Hanoi move sequencer: emits the optimal iterative move list for an
// S-disk stack from src_peg to dst_peg, one move per valid/ready handshake.
module hanoi_move_gen #(
   parameter int unsigned S = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           src_peg,
   input  logic [1:0]           dst_peg,
   input  logic                 abort,
   output logic                 mv_valid,
   input  logic                 mv_ready,
   output logic [1:0]           fr,
   output logic [1:0]           to,
   output logic [$clog2(S):0]   mv_disk,
   output logic [S-1:0]         mv_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned DW = $clog2(S) + 1;
   localparam logic [S-1:0] LAST = S'((1 << S) - 2);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t        r_state;
   logic [1:0]    r_src;
   logic [1:0]    r_dst;
   logic [1:0]    r_aux;
   logic [1:0]    r_disk_peg [S];
   logic [S-1:0]  r_cnt;
   logic          r_err;

   logic [S-1:0]  w_m;
   logic [DW-1:0] w_d;
   logic [1:0]    w_lf;
   logic [1:0]    w_lt;
   logic          w_odd;
   logic          w_acc;
   logic          w_start_ok;

   function automatic logic [1:0] phys(input logic [1:0] p, input logic [1:0] s,
                                       input logic [1:0] a, input logic [1:0] d);
      case (p)
         2'd0:    return s;
         2'd1:    return a;
         default: return d;
      endcase
   endfunction

   // Disk moved by move m is the trailing-zero count of m; pegs are kept in
   // logical form (0 src, 1 aux, 2 dst) and mapped to physical on output.
   always_comb begin
      w_m = r_cnt + 1'b1;
      w_d = '0;
      for (int unsigned i = S; i > 0; i--) begin
         if (w_m[i-1]) w_d = DW'(i - 1);
      end
      w_lf = 2'd0;
      for (int unsigned i = 0; i < S; i++) begin
         if (w_d == DW'(i)) w_lf = r_disk_peg[i];
      end
      w_odd = ((S % 2) == 1) ^ w_d[0];
      if (w_odd) w_lt = (w_lf == 2'd0) ? 2'd2 : (w_lf == 2'd2) ? 2'd1 : 2'd0;
      else       w_lt = (w_lf == 2'd2) ? 2'd0 : w_lf + 2'd1;
      w_acc      = (r_state == RUN) && mv_ready;
      w_start_ok = (src_peg != dst_peg) && (src_peg != 2'd3) && (dst_peg != 2'd3);
   end

   always_comb begin
      mv_valid = (r_state == RUN);
      busy     = (r_state == RUN);
      done     = (r_state == FIN);
      err      = r_err;
      mv_cnt   = r_cnt;
      fr       = '0;
      to       = '0;
      mv_disk  = '0;
      if (r_state == RUN) begin
         fr      = phys(w_lf, r_src, r_aux, r_dst);
         to      = phys(w_lt, r_src, r_aux, r_dst);
         mv_disk = w_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_aux   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         for (int unsigned i = 0; i < S; i++) r_disk_peg[i] <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (w_start_ok) begin
                     r_src   <= src_peg;
                     r_dst   <= dst_peg;
                     r_aux   <= 2'd3 - src_peg - dst_peg;
                     r_cnt   <= '0;
                     for (int unsigned i = 0; i < S; i++) r_disk_peg[i] <= '0;
                     r_state <= RUN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               // A handshake coinciding with abort still counts.
               if (w_acc) begin
                  for (int unsigned i = 0; i < S; i++) begin
                     if (w_d == DW'(i)) r_disk_peg[i] <= w_lt;
                  end
                  r_cnt <= w_m;
               end
               if (abort)                        r_state <= IDLE;
               else if (w_acc && r_cnt == LAST)  r_state <= FIN;
            end
            FIN:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
